// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard.
// Optional stall statistics counter is enabled by defining HAZARD_STATS_EN.
package hazard_pkg;
  localparam int TW = 3;

  // Tuse value meaning "this operand is not read".
  localparam logic [TW-1:0] TUSE_NONE = 3'd7;

  // Forwarding mux selects.
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  // One in-flight writer.
  typedef struct packed {
    logic          valid;
    logic          we;
    logic [4:0]    a3;
    logic [TW-1:0] tnew;
  } entry_t;

  // Advance an entry one stage: tnew counts down and sticks at zero.
  function automatic entry_t age_entry(entry_t x);
    entry_t r;
    r = x;
    if (r.tnew != '0) r.tnew = r.tnew - 1'b1;
    return r;
  endfunction

  // Entry will write src (r0 never counts as a hazard).
  function automatic logic writes(entry_t x, logic [4:0] src);
    return x.valid && x.we && (x.a3 != 5'd0) && (x.a3 == src);
  endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage decode fields in, stall/forward controls out.
// master = decoder/pipeline side, slave = scoreboard.
interface hazard_scoreboard_if;
  import hazard_pkg::*;

  logic          d_valid;
  logic [4:0]    d_rs;
  logic [4:0]    d_rt;
  logic [TW-1:0] d_tuse_rs;
  logic [TW-1:0] d_tuse_rt;
  logic          d_we;
  logic [4:0]    d_a3;
  logic [TW-1:0] d_tnew;
  logic          ext_stall;
  logic          flush;

  logic          stall;
  logic [1:0]    d_fwd_rs_sel;
  logic [1:0]    d_fwd_rt_sel;
  logic [1:0]    e_fwd_rs_sel;
  logic [1:0]    e_fwd_rt_sel;
  logic [31:0]   stall_cycles;

  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_we, d_a3, d_tnew,
           ext_stall, flush,
    input  stall, d_fwd_rs_sel, d_fwd_rt_sel, e_fwd_rs_sel, e_fwd_rt_sel,
           stall_cycles
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_we, d_a3, d_tnew,
           ext_stall, flush,
    output stall, d_fwd_rs_sel, d_fwd_rt_sel, e_fwd_rs_sel, e_fwd_rt_sel,
           stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard_match.sv
// Youngest-writer resolver for one source operand.
// The youngest matching entry alone decides: stall if its result arrives
// later than the operand is needed, forward its stage once tnew hits zero.
module hazard_match
  import hazard_pkg::*;
(
  input  logic [4:0]    src,
  input  logic [TW-1:0] tuse,
  input  entry_t        ent_e,
  input  entry_t        ent_m,
  input  entry_t        ent_w,
  output logic          stall_src,
  output logic [1:0]    sel
);
  logic          hit;
  logic [TW-1:0] tnew;
  logic [1:0]    code;

  // Priority pick E > M > W, then compare against tuse.
  always_comb begin
    hit       = 1'b0;
    tnew      = '0;
    code      = FWD_RF;
    stall_src = 1'b0;
    sel       = FWD_RF;
    if (writes(ent_e, src)) begin
      hit = 1'b1; tnew = ent_e.tnew; code = FWD_E;
    end else if (writes(ent_m, src)) begin
      hit = 1'b1; tnew = ent_m.tnew; code = FWD_M;
    end else if (writes(ent_w, src)) begin
      hit = 1'b1; tnew = ent_w.tnew; code = FWD_W;
    end
    if (hit && (tuse != TUSE_NONE)) begin
      stall_src = (tnew > tuse);
      if (tnew == '0) sel = code;
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks E/M/W writers, produces the D-stage
// stall and D/E forwarding selects. HAZARD_STATS_EN adds a saturating
// stall-cycle counter; without it stall_cycles is a constant zero.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  hazard_scoreboard_if.slave hif
);
  localparam int NSRC = 4; // 0: D rs, 1: D rt, 2: E rs, 3: E rt

  entry_t        ent_e, ent_m, ent_w;
  logic [4:0]    e_rs, e_rt;
  logic [TW-1:0] e_tuse_rs, e_tuse_rt;

  logic [NSRC-1:0][4:0]    src;
  logic [NSRC-1:0][TW-1:0] tuse;
  logic [NSRC-1:0]         stall_src;
  logic [NSRC-1:0][1:0]    sel;
  logic [1:0]              unused_e_stall;

  // An empty E slot must never request forwarding for stale operands.
  assign src  = {e_rt, e_rs, hif.d_rt, hif.d_rs};
  assign tuse = {ent_e.valid ? e_tuse_rt : TUSE_NONE,
                 ent_e.valid ? e_tuse_rs : TUSE_NONE,
                 hif.d_tuse_rt, hif.d_tuse_rs};

  // D sources see E/M/W; E sources see only the older M/W entries.
  for (genvar i = 0; i < NSRC; i++) begin : g_match
    hazard_match u_match (
      .src       (src[i]),
      .tuse      (tuse[i]),
      .ent_e     ((i < 2) ? ent_e : entry_t'('0)),
      .ent_m     (ent_m),
      .ent_w     (ent_w),
      .stall_src (stall_src[i]),
      .sel       (sel[i])
    );
  end

  assign unused_e_stall   = stall_src[3:2];
  assign hif.stall        = hif.d_valid & (stall_src[0] | stall_src[1]) & ~hif.flush;
  assign hif.d_fwd_rs_sel = sel[0];
  assign hif.d_fwd_rt_sel = sel[1];
  assign hif.e_fwd_rs_sel = sel[2];
  assign hif.e_fwd_rt_sel = sel[3];

  // Entry pipeline: flush > ext_stall (freeze) > stall (bubble) > advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_e     <= '0;
      ent_m     <= '0;
      ent_w     <= '0;
      e_rs      <= '0;
      e_rt      <= '0;
      e_tuse_rs <= TUSE_NONE;
      e_tuse_rt <= TUSE_NONE;
    end else if (hif.flush) begin
      ent_e     <= '0;
      ent_m     <= '0;
      ent_w     <= '0;
      e_rs      <= '0;
      e_rt      <= '0;
      e_tuse_rs <= TUSE_NONE;
      e_tuse_rt <= TUSE_NONE;
    end else if (!hif.ext_stall) begin
      ent_m <= age_entry(ent_e);
      ent_w <= age_entry(ent_m);
      if (hif.stall) begin
        ent_e     <= '0;
        e_rs      <= '0;
        e_rt      <= '0;
        e_tuse_rs <= TUSE_NONE;
        e_tuse_rt <= TUSE_NONE;
      end else begin
        ent_e     <= '{valid: hif.d_valid, we: hif.d_we, a3: hif.d_a3, tnew: hif.d_tnew};
        e_rs      <= hif.d_rs;
        e_rt      <= hif.d_rt;
        e_tuse_rs <= hif.d_tuse_rs;
        e_tuse_rt <= hif.d_tuse_rt;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;

  // Count real stall cycles only; frozen cycles are charged elsewhere.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (hif.stall && !hif.ext_stall && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign hif.stall_cycles = stall_cnt;
`else
  assign hif.stall_cycles = '0;
`endif
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Pipeline hazard controller that consumes the per-instruction decode fields (Tuse_Rs, Tuse_Rt, A3, Tnew, RegWriteNonZero) produced by the instruction decoder in D stage. It tracks every in-flight writer in E/M/W, ages its Tnew each cycle, and produces the D-stage stall plus forwarding selects for D-stage and E-stage operand reads. It sits beside the D/E/M/W pipeline registers of the FPGA CPU, with its outputs driving the PC/IR enables and the forwarding muxes.

## Interface
- TW, 3, width of Tuse/Tnew fields
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- d_valid  in  1  D stage holds a real instruction
- d_rs, d_rt  in  5 each  D-stage source registers
- d_tuse_rs, d_tuse_rt  in  TW each  cycles until operand needed; 7 = not used
- d_we  in  1  D instruction writes a nonzero register (RegWriteNonZero)
- d_a3  in  5  D instruction destination
- d_tnew  in  TW  cycles after entering E until result is forwardable
- ext_stall  in  1  freeze whole pipeline (e.g. multiply/divide busy)
- flush  in  1  kill all in-flight entries (exception/eret)
- stall  out  1  hold PC and D, insert bubble into E
- d_fwd_rs_sel, d_fwd_rt_sel  out  2 each  0 RF, 1 E, 2 M, 3 W
- e_fwd_rs_sel, e_fwd_rt_sel  out  2 each  0 pipeline value, 2 M, 3 W
- stall_cycles  out  32  stall-cycle count (see Configuration)

## Operation
- Three entry registers E, M, W; each holds valid, we, a3, tnew; E also holds rs, rt, tuse_rs, tuse_rt.
- Match: entry valid, we=1, a3≠0, a3 equals the source register.
- Per D source: the youngest matching entry (E>M>W) decides. stall_src = youngest.tnew > tuse; forward that stage if youngest.tnew = 0, else 0. tuse=7 never stalls and forwards 0.
- stall = d_valid & (stall_rs | stall_rt) & ~flush.
- E-stage sources: youngest matching of M, W with tnew=0 → 2/3; else 0. Only for E entries whose stored tuse≠7.
- Update priority per edge: flush > ext_stall > stall > normal.
  - flush: all entries invalid.
  - ext_stall: all entries hold, no tnew decrement.
  - stall: E←bubble; M←E; W←M, with aging.
  - normal: E←D fields (valid=d_valid), tnew=d_tnew; M←E; W←M, with aging.
- Aging on each E→M and M→W move: tnew ← max(tnew−1, 0), never wraps.

## Timing
- After reset: all entries invalid; stall=0, all fwd selects 0, stall_cycles=0.
- stall and fwd selects are combinational from current entries plus D inputs, with zero-cycle latency.
- Entry registers update on the clk edge. Reset deasserted mid-operation resumes from the empty state.
- flush asserted while stall=1: stall forced 0 that cycle; next cycle all entries are empty.
- Simultaneous ext_stall and stall: the pipeline holds and no bubble is inserted; the stall output remains asserted.
- d_valid=0 in the normal case loads a bubble into E.

## Configuration
- HAZARD_STATS_EN defined: stall_cycles increments on every edge where stall=1 & ~ext_stall, saturates at 32'hFFFFFFFF, and clears on reset.
- HAZARD_STATS_EN undefined: stall_cycles is tied to 0 and no counter flops exist.

## Structure
- Package hazard_pkg:
  - TUSE_NONE=3'd7.
  - Forward codes FWD_RF/FWD_E/FWD_M/FWD_W.
  - Packed entry typedef (valid, we, a3, tnew).
- Sub-module hazard_match: combinational youngest-match resolver, instantiated once per source (four instances). Inputs are src, tuse, and the entries; outputs are stall_src and sel.

## Test plan
- Reset low for 3 cycles, then release with no instructions: all outputs stay 0.
- addu (we=1, a3=1, tnew=1), then beq with rs=1, tuse_rs=0: stall=1 for exactly one cycle, then d_fwd_rs_sel=2 and stall=0.
- lw (a3=2, tnew=2), then addu with rs=2, tuse_rs=1: one stall cycle; when the addu is in E, e_fwd_rs_sel=3.
- Writer with a3=0 or d_we=0 (tnew=2), then reader with rs=0 or a matching rs and tuse=0: stall=0 and fwd=0.
- ext_stall held for 4 cycles behind lw (tnew=2):
  - Entries keep tnew and stall persists.
  - After release, aging resumes.
  - With HAZARD_STATS_EN, stall_cycles does not count frozen cycles.
- flush during a load-use stall:
  - stall drops immediately.
  - Next cycle all selects are 0 for any D source.
